// File: rtl/if_id_queue_pkg.sv
// Shared constants and bundle layout helpers for the fetch->decode queue.
// A stored bundle is packed as {pc, pred, iv, instr}, with instr at bit 0.
package if_id_queue_pkg;

  localparam int IF_LANES = 2;
  localparam int IF_IW    = 16;
  localparam int IF_PCW   = 16;
  localparam int IF_IMMW  = 6;

  function automatic int off_iv(input int lanes, input int iw);
    return lanes * iw;
  endfunction

  function automatic int off_pred(input int lanes, input int iw);
    return lanes * (iw + 1);
  endfunction

  function automatic int off_pc(input int lanes, input int iw);
    return lanes * (iw + 2);
  endfunction

  function automatic int bundle_w(input int lanes, input int iw, input int pcw);
    return lanes * (iw + 2 + pcw);
  endfunction

endpackage

// File: rtl/if_id_queue_bundle_reg.sv
// One bundle of LANES instructions with load enable; holds data only, so no reset.
module if_id_bundle_reg
  import if_id_queue_pkg::*;
#(
  parameter int LANES = IF_LANES,
  parameter int IW    = IF_IW,
  parameter int PCW   = IF_PCW
) (
  input  logic                 clk,
  input  logic                 load,
  input  logic [LANES*IW-1:0]  d_instr,
  input  logic [LANES-1:0]     d_iv,
  input  logic [LANES-1:0]     d_pred,
  input  logic [LANES*PCW-1:0] d_pc,
  output logic [LANES*IW-1:0]  q_instr,
  output logic [LANES-1:0]     q_iv,
  output logic [LANES-1:0]     q_pred,
  output logic [LANES*PCW-1:0] q_pc
);

  logic [LANES*IW-1:0]  instr_q, instr_d;
  logic [LANES-1:0]     iv_q, iv_d;
  logic [LANES-1:0]     pred_q, pred_d;
  logic [LANES*PCW-1:0] pc_q, pc_d;

  always_comb begin
    instr_d = instr_q;
    iv_d    = iv_q;
    pred_d  = pred_q;
    pc_d    = pc_q;
    if (load) begin
      instr_d = d_instr;
      iv_d    = d_iv;
      pred_d  = d_pred;
      pc_d    = d_pc;
    end
  end

  always_ff @(posedge clk) begin
    instr_q <= instr_d;
    iv_q    <= iv_d;
    pred_q  <= pred_d;
    pc_q    <= pc_d;
  end

  assign q_instr = instr_q;
  assign q_iv    = iv_q;
  assign q_pred  = pred_q;
  assign q_pc    = pc_q;

endmodule

// File: rtl/if_id_queue.sv
// Fetch->decode bundle queue with a one-bundle replay slot that takes priority
// over the queue head, plus the registered immediate history used by decode.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int LANES = IF_LANES,
  parameter int DEPTH = 4,
  parameter int IW    = IF_IW,
  parameter int PCW   = IF_PCW,
  parameter int IMMW  = IF_IMMW
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES*IW-1:0]          in_instr,
  input  logic [LANES-1:0]             in_iv,
  input  logic [LANES-1:0]             in_pred,
  input  logic [LANES*PCW-1:0]         in_pc,
  input  logic                         loop_valid,
  output logic                         loop_ready,
  input  logic [LANES*IW-1:0]          loop_instr,
  input  logic [LANES-1:0]             loop_iv,
  input  logic [LANES-1:0]             loop_pred,
  input  logic [LANES*PCW-1:0]         loop_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*IW-1:0]          out_instr,
  output logic [LANES-1:0]             out_iv,
  output logic [LANES-1:0]             out_pred,
  output logic [LANES*PCW-1:0]         out_pc,
  input  logic [LANES*IMMW-1:0]        imm_in,
  output logic [LANES*IMMW-1:0]        prev_imm,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH+1);
  localparam int OIV = off_iv(LANES, IW);
  localparam int OPR = off_pred(LANES, IW);
  localparam int OPC = off_pc(LANES, IW);
  localparam int BW  = bundle_w(LANES, IW, PCW);

  logic [BW-1:0]         mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  slot_full_q, slot_full_d;
  logic [LANES*IMMW-1:0] prev_imm_q, prev_imm_d;

  logic [LANES*IW-1:0]   slot_instr;
  logic [LANES-1:0]      slot_iv, slot_pred;
  logic [LANES*PCW-1:0]  slot_pc;
  logic [BW-1:0]         head, in_bundle;
  logic                  push, store, rpush, pop, pop_slot, pop_head, head_valid, mem_we;

  assign in_ready   = (count_q < CW'(DEPTH));
  assign loop_ready = !slot_full_q;
  assign head_valid = (count_q != '0);
  assign push       = in_valid & in_ready;
  // All-lanes-invalid bundles are accepted but never occupy an entry.
  assign store      = push & (|in_iv);
  assign rpush      = loop_valid & loop_ready;
  assign out_valid  = slot_full_q | head_valid;
  assign pop        = out_valid & out_ready;
  assign pop_slot   = pop & slot_full_q;
  assign pop_head   = pop & !slot_full_q;
  assign mem_we     = store & !flush;
  assign in_bundle  = {in_pc, in_pred, in_iv, in_instr};
  assign head       = mem_q[rd_ptr_q];
  assign prev_imm   = prev_imm_q;
  assign occupancy  = count_q;

  if_id_bundle_reg #(.LANES(LANES), .IW(IW), .PCW(PCW)) u_slot (
    .clk     (clk),
    .load    (rpush & !flush),
    .d_instr (loop_instr),
    .d_iv    (loop_iv),
    .d_pred  (loop_pred),
    .d_pc    (loop_pc),
    .q_instr (slot_instr),
    .q_iv    (slot_iv),
    .q_pred  (slot_pred),
    .q_pc    (slot_pc)
  );

  always_comb begin
    out_instr = '0;
    out_iv    = '0;
    out_pred  = '0;
    out_pc    = '0;
    if (slot_full_q) begin
      out_instr = slot_instr;
      out_iv    = slot_iv;
      out_pred  = slot_pred;
      out_pc    = slot_pc;
    end else if (head_valid) begin
      out_instr = head[0   +: LANES*IW];
      out_iv    = head[OIV +: LANES];
      out_pred  = head[OPR +: LANES];
      out_pc    = head[OPC +: LANES*PCW];
    end
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q + PW'(store);
    rd_ptr_d    = rd_ptr_q + PW'(pop_head);
    count_d     = count_q + CW'(store) - CW'(pop_head);
    // The slot can only be loaded while empty, so a pop and a load never coincide.
    slot_full_d = slot_full_q ? !pop_slot : rpush;
    prev_imm_d  = pop ? imm_in : prev_imm_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      slot_full_d = 1'b0;
      prev_imm_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      slot_full_q <= 1'b0;
      prev_imm_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      slot_full_q <= slot_full_d;
      prev_imm_q  <= prev_imm_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= in_bundle;
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: stimulus pushes expected bundles, a negedge
// monitor pops and compares every bundle the decoder side consumes.
module tb_if_id_queue;

  typedef struct packed {
    logic [31:0] instr;
    logic [1:0]  iv;
    logic [1:0]  pred;
    logic [31:0] pc;
  } bun_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0, loop_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, loop_ready, out_valid;
  logic [31:0] in_instr = '0, loop_instr = '0, out_instr;
  logic [1:0]  in_iv = '0, in_pred = '0, loop_iv = '0, loop_pred = '0, out_iv, out_pred;
  logic [31:0] in_pc = '0, loop_pc = '0, out_pc;
  logic [11:0] imm_in = '0, prev_imm;
  logic [2:0]  occupancy;

  int   total = 0;
  int   bad = 0;
  bun_t expq[$];
  logic [11:0] exp_prev = '0;

  if_id_queue dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_iv(in_iv),
    .in_pred(in_pred), .in_pc(in_pc),
    .loop_valid(loop_valid), .loop_ready(loop_ready), .loop_instr(loop_instr),
    .loop_iv(loop_iv), .loop_pred(loop_pred), .loop_pc(loop_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_iv(out_iv),
    .out_pred(out_pred), .out_pc(out_pc),
    .imm_in(imm_in), .prev_imm(prev_imm), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  function automatic bun_t mk(input logic [15:0] pc, input logic [1:0] iv);
    bun_t b;
    b.instr = {pc ^ 16'hBEEF, pc ^ 16'h1234};
    b.iv    = iv;
    b.pred  = {pc[1], pc[2]};
    b.pc    = {pc + 16'd1, pc};
    return b;
  endfunction

  task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_b(input logic [15:0] pc, input logic [1:0] iv);
    bun_t b;
    logic acc;
    b = mk(pc, iv);
    in_valid = 1'b1; in_instr = b.instr; in_iv = b.iv; in_pred = b.pred; in_pc = b.pc;
    #1 acc = in_ready;
    @(posedge clk);
    if (acc && !flush && iv != 2'b00) expq.push_back(b);
    #1 in_valid = 1'b0;
  endtask

  task automatic rpush_b(input logic [15:0] pc);
    bun_t b;
    logic acc;
    b = mk(pc, 2'b11);
    loop_valid = 1'b1; loop_instr = b.instr; loop_iv = b.iv; loop_pred = b.pred; loop_pc = b.pc;
    #1 acc = loop_ready;
    @(posedge clk);
    if (acc && !flush) expq.push_front(b);
    #1 loop_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (expq.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(name, expq.size(), 0);
  endtask

  // Monitor: consumed bundles against the scoreboard, idle zeroing, imm history.
  initial begin
    bun_t got, exp;
    forever begin
      @(negedge clk);
      if (!reset) begin
        exp_prev = '0;
      end else begin
        check("prev_imm", prev_imm, exp_prev);
        if (!out_valid) check("idle_out_zero", {out_instr, out_iv, out_pred, out_pc}, 0);
        if (out_valid && out_ready && !flush) begin
          got = {out_instr, out_iv, out_pred, out_pc};
          if (expq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out got_pc=%0h exp=none", out_pc[15:0]);
          end else begin
            exp = expq.pop_front();
            check("out_bundle", got, exp);
          end
          exp_prev = imm_in;
        end
        if (flush) exp_prev = '0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1 reset / idle
    repeat (3) tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_loop_ready", loop_ready, 1);
    check("rst_occupancy", occupancy, 0);
    check("rst_prev_imm", prev_imm, 0);
    reset = 1'b1;
    tick();

    // 2 fill / drain, no full-bypass
    out_ready = 1'b0;
    push_b(16'h10, 2'b11);
    push_b(16'h12, 2'b11);
    push_b(16'h14, 2'b01);
    push_b(16'h16, 2'b10);
    check("full_in_ready", in_ready, 0);
    check("full_occupancy", occupancy, 4);
    push_b(16'h18, 2'b11);
    check("full_reject_occ", occupancy, 4);
    out_ready = 1'b1;
    #1 check("no_bypass_in_ready", in_ready, 0);
    tick();
    check("drain_step_occ", occupancy, 3);
    drain("fill_drain_empty");
    check("drained_occ", occupancy, 0);

    // 3 wrap with concurrent push/pop
    push_b(16'h30, 2'b11);
    check("wrap_start_occ", occupancy, 1);
    for (int k = 0; k < 10; k++) begin
      push_b(16'h32 + 16'(2 * k), 2'b11);
      check("wrap_occ", occupancy, 1);
    end
    drain("wrap_drain_empty");
    out_ready = 1'b0;

    // 4 replay priority
    push_b(16'h20, 2'b11);
    push_b(16'h22, 2'b11);
    rpush_b(16'h40);
    check("replay_loop_ready", loop_ready, 0);
    check("replay_out_pc", out_pc[15:0], 16'h40);
    check("replay_occ", occupancy, 2);
    imm_in = 12'hA5A;
    out_ready = 1'b1;
    tick();
    check("replay_slot_freed", loop_ready, 1);
    drain("replay_drain_empty");
    out_ready = 1'b0;
    imm_in = 12'h000;
    tick();

    // 5 flush collision
    push_b(16'h50, 2'b11);
    push_b(16'h52, 2'b11);
    push_b(16'h54, 2'b11);
    rpush_b(16'h60);
    check("pre_flush_occ", occupancy, 3);
    check("pre_flush_loop_ready", loop_ready, 0);
    begin
      bun_t b;
      b = mk(16'h70, 2'b11);
      in_valid = 1'b1; in_instr = b.instr; in_iv = b.iv; in_pred = b.pred; in_pc = b.pc;
    end
    flush = 1'b1;
    out_ready = 1'b1;
    imm_in = 12'hFFF;
    #1;
    check("flush_cycle_in_ready", in_ready, 1);
    check("flush_cycle_loop_ready", loop_ready, 0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    imm_in = 12'h000;
    expq.delete();
    check("flush_out_valid", out_valid, 0);
    check("flush_occ", occupancy, 0);
    check("flush_prev_imm", prev_imm, 0);
    check("flush_loop_ready", loop_ready, 1);
    repeat (2) tick();
    check("flush_push_absent", out_valid, 0);

    // 6 empty-bundle drop and imm history
    push_b(16'h80, 2'b11);
    check("drop_pre_occ", occupancy, 1);
    push_b(16'h82, 2'b00);
    check("drop_occ", occupancy, 1);
    imm_in = {6'h2A, 6'h15};
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("imm_capture", prev_imm, {6'h2A, 6'h15});
    check("drop_after_pop_occ", occupancy, 0);
    check("drop_absent", out_valid, 0);
    imm_in = 12'h000;
    repeat (2) tick();
    check("imm_hold", prev_imm, {6'h2A, 6'h15});
    check("final_queue_empty", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
